delay_probe: RTL and testbench

//  Measures the latency (in clk cycles) of a delay_line or any N-bit pipeline under test.
//  - Drives the pipeline input (odata) and watches its output (idata), closing the loop.
//  - On start: flushes the line with zeros, launches one PROBE word, then counts cycles until PROBE returns.
//  - Reports latency, or timeout if PROBE does not return within MAX_DELAY cycles. Used for bring-up and self-test.

---
 rtl/delay_pkg.sv | 11 +
 rtl/delay_probe_if.sv | 15 +
 rtl/sat_counter.sv | 16 +
 rtl/delay_probe.sv | 68 ++++++
 tb/tb_delay_probe.sv | 117 +++++++++++
 5 files changed

// File: rtl/delay_pkg.sv
// delay_pkg: shared FSM state encoding and default probe settings for delay_probe
package delay_pkg;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FLUSH  = 3'd1;
  localparam logic [2:0] ST_PROBE  = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_REPORT = 3'd4;
  localparam int DEF_N = 3;
  localparam int DEF_MAX_DELAY = 15;
  localparam logic [DEF_N-1:0] DEF_PROBE = '1;
endpackage

// File: rtl/delay_probe_if.sv
// delay_probe_if: control, result and loop signals between delay_probe and its pipeline under test
interface delay_probe_if #(
  parameter int N = 3,
  parameter int CW = 4
);
  logic start;
  logic [N-1:0] odata;
  logic [N-1:0] idata;
  logic busy;
  logic done;
  logic timeout;
  logic [CW-1:0] latency;
  modport master (output start, idata, input odata, busy, done, timeout, latency);
  modport slave (input start, idata, output odata, busy, done, timeout, latency);
endinterface

// File: rtl/sat_counter.sv
// sat_counter: up counter with sync clear and enable that stops at MAX and flags it
module sat_counter #(
  parameter int CW = 4,
  parameter int MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic [CW-1:0] q,
  output logic at_max
);
  assign at_max = q == CW'(MAX);
  always_ff @(posedge clk)
    q <= (rst || clr) ? '0 : (en && !at_max) ? q + 1'b1 : q;
endmodule

// File: rtl/delay_probe.sv
// delay_probe: measures the cycle latency of an N-bit pipeline by launching a probe word into it
module delay_probe
  import delay_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int MAX_DELAY = DEF_MAX_DELAY,
  parameter logic [N-1:0] PROBE = '1,
  parameter int CW = $clog2(MAX_DELAY + 1)
) (
  input logic clk,
  input logic rst,
  delay_probe_if.slave bus
);
  logic [2:0] state, nxt;
  logic ok, nxt_ok, hit, f_max, c_max;
  logic [CW-1:0] fcnt, cnt, lat, nxt_lat;
  wire unused = &{1'b0, fcnt};
  assign hit = bus.idata == PROBE;
  sat_counter #(.CW(CW), .MAX(MAX_DELAY)) u_fcnt (
    .clk(clk), .rst(rst), .clr(state == ST_IDLE), .en(state == ST_FLUSH),
    .q(fcnt), .at_max(f_max)
  );
  // cnt sits at 0 through FLUSH/PROBE, so the k-th WAIT cycle sees cnt == k
  sat_counter #(.CW(CW), .MAX(MAX_DELAY)) u_cnt (
    .clk(clk), .rst(rst), .clr(state != ST_PROBE && state != ST_WAIT),
    .en(state == ST_PROBE || state == ST_WAIT), .q(cnt), .at_max(c_max)
  );
  always_comb begin
    nxt = state;
    nxt_ok = ok;
    nxt_lat = lat;
    case (state)
      ST_IDLE: if (bus.start) begin
        nxt = ST_FLUSH;
        nxt_lat = '0;
      end
      ST_FLUSH: if (f_max) nxt = ST_PROBE;
      ST_PROBE: begin
        nxt = hit ? ST_REPORT : ST_WAIT;
        nxt_ok = hit;
      end
      ST_WAIT: if (hit) begin
        nxt = ST_REPORT;
        nxt_ok = 1'b1;
        nxt_lat = cnt;
      end else if (c_max) begin
        nxt = ST_REPORT;
        nxt_ok = 1'b0;
      end
      default: nxt = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= ST_IDLE;
      ok <= 1'b0;
      lat <= '0;
    end else begin
      state <= nxt;
      ok <= nxt_ok;
      lat <= nxt_lat;
    end
  assign bus.odata = state == ST_PROBE ? PROBE : '0;
  assign bus.busy = state == ST_FLUSH || state == ST_PROBE || state == ST_WAIT;
  assign bus.done = state == ST_REPORT && ok;
  assign bus.timeout = state == ST_REPORT && !ok;
  assign bus.latency = lat;
endmodule

// File: tb/tb_delay_probe.sv
// tb_delay_probe: closes delay_probe around a modelled pipeline and scoreboards each measurement
module tb_delay_probe;
  import delay_pkg::*;
  localparam int MAXD = 15;
  typedef struct {
    bit ok;
    int lat;
    int bc;
  } exp_t;
  logic clk = 0;
  logic rst = 1;
  int mode = 2;
  int dly = 1;
  int compared = 0;
  int mismatched = 0;
  exp_t sb[$];
  logic [2:0] sr [16];
  delay_probe_if #(.N(3), .CW(4)) bus ();
  delay_probe #(.N(3), .MAX_DELAY(MAXD)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #1 clk = ~clk;
  always @(posedge clk) begin
    sr[0] <= bus.odata;
    for (int i = 1; i < 16; i++) sr[i] <= sr[i-1];
  end
  // mode 0: register chain of dly stages, 1: wire, 2: stuck at zero
  assign bus.idata = mode == 1 ? bus.odata : mode == 2 ? 3'b000 : sr[dly-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic measure(input int m, input int d, input int poke);
    exp_t e, g;
    int bc, od, extra;
    bit got;
    mode = m;
    dly = d;
    e.ok = (m == 1) || (m == 0 && d <= MAXD);
    e.lat = (m == 0 && e.ok) ? d : 0;
    e.bc = 17 + (m == 1 ? 0 : e.ok ? d : MAXD);
    sb.push_back(e);
    @(negedge clk) bus.start = 1;
    @(negedge clk) bus.start = 0;
    bc = 0;
    od = 0;
    got = 0;
    for (int i = 0; i < 80; i++) begin
      bus.start = (i == poke);
      if (bus.busy) bc++;
      if (bus.odata != 0) od++;
      if (bus.done || bus.timeout) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    bus.start = 0;
    chk("result_seen", got, 1);
    g = sb.pop_front();
    chk("done", bus.done, g.ok);
    chk("timeout", bus.timeout, !g.ok);
    chk("latency", bus.latency, g.lat);
    chk("busy_cycles", bc, g.bc);
    chk("probe_cycles", od, 1);
    @(negedge clk);
    chk("pulse_end", {bus.done, bus.timeout, bus.busy}, 0);
    chk("latency_held", bus.latency, g.lat);
    if (poke >= 0) begin
      extra = 0;
      for (int i = 0; i < 25; i++) begin
        if (bus.busy || bus.done || bus.timeout) extra++;
        @(negedge clk);
      end
      chk("no_requeue", extra, 0);
    end
  endtask

  initial begin
    bus.start = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_timeout", bus.timeout, 0);
    chk("rst_latency", bus.latency, 0);
    chk("rst_odata", bus.odata, 0);
    rst = 0;
    @(negedge clk);
    measure(0, 4, -1);
    measure(1, 1, -1);
    measure(2, 1, -1);
    measure(0, 15, -1);
    measure(0, 16, -1);
    measure(0, 4, 18);
    measure(0, 1, -1);
    mode = 0;
    dly = 4;
    @(negedge clk) bus.start = 1;
    @(negedge clk) bus.start = 0;
    repeat (18) @(negedge clk);
    chk("mid_busy", bus.busy, 1);
    rst = 1;
    @(negedge clk);
    chk("abort_busy", bus.busy, 0);
    chk("abort_odata", bus.odata, 0);
    chk("abort_latency", bus.latency, 0);
    chk("abort_done", bus.done, 0);
    rst = 0;
    measure(0, 4, -1);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
